mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/lc3b_types.sv | 38 +++
 rtl/arb_request_reg.sv | 29 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b bus types plus the memory arbiter's state, port and request types.
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  // One captured downstream transaction: 12 + 128 + 16 + 2 bits.
  typedef struct packed {
    lc3b_wb_adr addr;
    lc3b_line   wdata;
    lc3b_word   sel;
    logic       write;
    logic       read;
  } arb_req_t;

  localparam int ARB_REQ_W = $bits(arb_req_t);

  // Winner among pending ports; on a tie the port that did not win last time goes.
  function automatic arb_port_t pick_port(input logic i_pend, input logic d_pend,
                                          input arb_port_t last);
    if (i_pend && d_pend) return (last == PORT_I) ? PORT_D : PORT_I;
    else if (d_pend)      return PORT_D;
    else                  return PORT_I;
  endfunction

endpackage

// File: rtl/arb_request_reg.sv
// Request register: holds the granted transaction for the whole SERVE phase.
module arb_request_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  arb_req_t req_in,
  output arb_req_t req_out
);

  arb_req_t req_d, req_q;

  always_comb begin
    // NOTE: default first so every path assigns req_d and no latch is inferred.
    req_d = req_q;
    if (load) req_d = req_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: cleared on reset so the downstream bus shows zeros; bulk storage arrays are normally left unreset.
    if (rst) req_q <= '0;
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    else     req_q <= req_d;
  end

  assign req_out = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one line-wide physical memory between
// the instruction fetch port and the data port.
module mem_arbiter
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,

  input  logic       ifetch_read,
  input  lc3b_wb_adr ifetch_address,
  output lc3b_line   ifetch_rdata,
  output logic       ifetch_resp,

  input  logic       mem_read,
  input  logic       mem_write,
  input  lc3b_wb_adr mem_address,
  input  lc3b_line   mem_wdata,
  input  lc3b_word   mem_sel,
  output lc3b_line   mem_rdata,
  output logic       mem_resp,

  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_wb_adr pmem_address,
  output lc3b_line   pmem_wdata,
  output lc3b_word   pmem_sel,
  input  lc3b_line   pmem_rdata,
  input  logic       pmem_resp
);

  arb_state_t state_d, state_q;
  arb_port_t  last_d, last_q;
  arb_port_t  grant_port;
  logic       data_pend;
  logic       grant_load;
  arb_req_t   req_in, req_q;

  assign data_pend = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_I;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_load  = 1'b0;
    grant_port  = PORT_I;
    req_in      = '0;
    ifetch_resp = 1'b0;
    mem_resp    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ifetch_read || data_pend) begin
          grant_port = pick_port(ifetch_read, data_pend, last_q);
          grant_load = 1'b1;
          last_d     = grant_port;
          if (grant_port == PORT_D) begin
            // Read and write together is treated as a write.
            req_in.addr  = mem_address;
            req_in.wdata = mem_wdata;
            req_in.sel   = mem_sel;
            req_in.write = mem_write;
            req_in.read  = ~mem_write;
            state_d      = SERVE_D;
          end else begin
            req_in.addr  = ifetch_address;
            req_in.read  = 1'b1;
            state_d      = SERVE_I;
          end
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          ifetch_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          mem_resp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  arb_request_reg u_request_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_load),
    .req_in  (req_in),
    .req_out (req_q)
  );

  // Downstream side comes only from registered state, never from requester inputs.
  assign pmem_read    = (state_q != IDLE) & req_q.read;
  assign pmem_write   = (state_q != IDLE) & req_q.write;
  assign pmem_address = req_q.addr;
  assign pmem_wdata   = req_q.wdata;
  assign pmem_sel     = req_q.sel;

  assign ifetch_rdata = pmem_rdata;
  assign mem_rdata    = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, round-robin, write capture,
// read+write priority, mid-transaction reset and spurious downstream response.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifetch_read;
  lc3b_wb_adr ifetch_address;
  lc3b_line   ifetch_rdata;
  logic       ifetch_resp;
  logic       mem_read, mem_write;
  lc3b_wb_adr mem_address;
  lc3b_line   mem_wdata;
  lc3b_word   mem_sel;
  lc3b_line   mem_rdata;
  logic       mem_resp;
  logic       pmem_read, pmem_write;
  lc3b_wb_adr pmem_address;
  lc3b_line   pmem_wdata;
  lc3b_word   pmem_sel;
  lc3b_line   pmem_rdata;
  logic       pmem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifetch_read(ifetch_read), .ifetch_address(ifetch_address),
    .ifetch_rdata(ifetch_rdata), .ifetch_resp(ifetch_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_sel(pmem_sel), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  task automatic idle_inputs();
    ifetch_read = 1'b0; ifetch_address = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0; mem_sel = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits a bounded number of edges for a downstream strobe.
  task automatic wait_strobe(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (pmem_read || pmem_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    pmem_resp = 1'b1;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", pmem_read, pmem_write); end
    checks++; if (ifetch_resp !== 1'b0 || mem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", ifetch_resp, mem_resp); end
    checks++; if (pmem_address !== 12'h000 || pmem_sel !== 16'h0000) begin errors++; $display("FAIL reset_addr_sel: got %h %h want 000 0000", pmem_address, pmem_sel); end
    checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", pmem_wdata); end
    pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single_ifetch();
    ifetch_read = 1'b1; ifetch_address = 12'h010;
    #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL single_no_comb_strobe: got %b want 0", pmem_read); end
    @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin errors++; $display("FAIL single_strobe_latency: got r=%b w=%b want 1 0", pmem_read, pmem_write); end
    checks++; if (pmem_address !== 12'h010) begin errors++; $display("FAIL single_addr: got %h want 010", pmem_address); end
    repeat (2) @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b1) begin errors++; $display("FAIL single_strobe_held: got %b want 1", pmem_read); end
    pmem_rdata = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
    pmem_resp = 1'b1;
    #1;
    checks++; if (ifetch_resp !== 1'b1 || mem_resp !== 1'b0) begin errors++; $display("FAIL single_resp: got i=%b d=%b want 1 0", ifetch_resp, mem_resp); end
    checks++; if (ifetch_rdata !== 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004) begin errors++; $display("FAIL single_rdata: got %h want cafe0001...", ifetch_rdata); end
    @(posedge clk); #1;
    pmem_resp = 1'b0; ifetch_read = 1'b0;
    #1;
    checks++; if (ifetch_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL single_after: got resp=%b r=%b want 0 0", ifetch_resp, pmem_read); end
    checks++; if (pmem_address !== 12'h010) begin errors++; $display("FAIL single_addr_hold: got %h want 010", pmem_address); end
  endtask

  task automatic test_round_robin();
    bit ok;
    bit exp_d;
    lc3b_line line;
    do_reset();
    ifetch_read = 1'b1; ifetch_address = 12'h111;
    mem_read = 1'b1;    mem_address = 12'h222;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      wait_strobe(4, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout: grant %0d got no strobe want strobe", k); end
      checks++; if (pmem_address !== (exp_d ? 12'h222 : 12'h111)) begin errors++; $display("FAIL rr_order: grant %0d got addr %h want %h", k, pmem_address, exp_d ? 12'h222 : 12'h111); end
      line = {4{32'hA5A5_0000 + 32'(k)}};
      pmem_rdata = line;
      pmem_resp = 1'b1;
      #1;
      checks++; if (mem_resp !== exp_d || ifetch_resp !== !exp_d) begin errors++; $display("FAIL rr_resp: grant %0d got i=%b d=%b want i=%b d=%b", k, ifetch_resp, mem_resp, !exp_d, exp_d); end
      checks++; if ((exp_d ? mem_rdata : ifetch_rdata) !== line) begin errors++; $display("FAIL rr_rdata: grant %0d got %h want %h", k, exp_d ? mem_rdata : ifetch_rdata, line); end
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      #1;
      checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL rr_turnaround: grant %0d got r=%b w=%b want 0 0", k, pmem_read, pmem_write); end
    end
    ifetch_read = 1'b0; mem_read = 1'b0;
  endtask

  task automatic test_write_capture();
    bit ok;
    mem_write = 1'b1; mem_address = 12'hABC; mem_sel = 16'h00FF;
    mem_wdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    wait_strobe(4, ok);
    checks++; if (!ok || pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errors++; $display("FAIL wr_strobe: got ok=%b r=%b w=%b want 1 0 1", ok, pmem_read, pmem_write); end
    mem_write = 1'b0; mem_address = 12'h555; mem_sel = 16'hFF00; mem_wdata = '1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 12'hABC || pmem_sel !== 16'h00FF ||
          pmem_wdata !== 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321) begin
        errors++;
        $display("FAIL wr_stable: cycle %0d got w=%b addr=%h sel=%h wdata=%h want 1 abc 00ff 1234...4321", c, pmem_write, pmem_address, pmem_sel, pmem_wdata);
      end
    end
    pmem_resp = 1'b1;
    #1;
    checks++; if (mem_resp !== 1'b1 || ifetch_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_after_drop: got d=%b i=%b want 1 0", mem_resp, ifetch_resp); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
    checks++; if (pmem_write !== 1'b0 || pmem_address !== 12'hABC) begin errors++; $display("FAIL wr_idle_hold: got w=%b addr=%h want 0 abc", pmem_write, pmem_address); end
  endtask

  task automatic test_rw_both();
    bit ok;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 12'h0F0; mem_sel = 16'hFFFF;
    wait_strobe(4, ok);
    checks++; if (!ok || pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errors++; $display("FAIL rw_is_write: got ok=%b r=%b w=%b want 1 0 1", ok, pmem_read, pmem_write); end
    mem_read = 1'b0; mem_write = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++; if (mem_resp !== 1'b1) begin errors++; $display("FAIL rw_resp: got %b want 1", mem_resp); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    ifetch_read = 1'b1; ifetch_address = 12'h333;
    wait_strobe(4, ok);
    checks++; if (!ok || pmem_read !== 1'b1 || pmem_address !== 12'h333) begin errors++; $display("FAIL rmid_start: got ok=%b r=%b addr=%h want 1 1 333", ok, pmem_read, pmem_address); end
    @(posedge clk); #1;
    rst = 1'b1; pmem_resp = 1'b1;
    #1;
    checks++; if (pmem_read !== 1'b0 || ifetch_resp !== 1'b0 || mem_resp !== 1'b0) begin errors++; $display("FAIL rmid_abort: got r=%b i=%b d=%b want 0 0 0", pmem_read, ifetch_resp, mem_resp); end
    checks++; if (pmem_address !== 12'h000) begin errors++; $display("FAIL rmid_addr_clear: got %h want 000", pmem_address); end
    @(posedge clk); #1;
    rst = 1'b0; pmem_resp = 1'b0;
    ifetch_address = 12'h444; mem_read = 1'b1; mem_address = 12'h555;
    wait_strobe(4, ok);
    checks++; if (!ok || pmem_address !== 12'h555 || pmem_read !== 1'b1) begin errors++; $display("FAIL rmid_tie_data: got ok=%b addr=%h r=%b want 1 555 1", ok, pmem_address, pmem_read); end
    ifetch_read = 1'b0; mem_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++; if (mem_resp !== 1'b1 || ifetch_resp !== 1'b0) begin errors++; $display("FAIL rmid_resp: got d=%b i=%b want 1 0", mem_resp, ifetch_resp); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  task automatic test_spurious_resp();
    pmem_rdata = 128'hDEAD;
    pmem_resp = 1'b1;
    #1;
    checks++; if (ifetch_resp !== 1'b0 || mem_resp !== 1'b0) begin errors++; $display("FAIL spur_resp: got i=%b d=%b want 0 0", ifetch_resp, mem_resp); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL spur_strobes: got r=%b w=%b want 0 0", pmem_read, pmem_write); end
    ifetch_read = 1'b1; ifetch_address = 12'h777;
    @(posedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 12'h777) begin errors++; $display("FAIL spur_still_idle: got r=%b addr=%h want 1 777", pmem_read, pmem_address); end
    ifetch_read = 1'b0;
    pmem_resp = 1'b1;
    #1;
    checks++; if (ifetch_resp !== 1'b1) begin errors++; $display("FAIL spur_followup_resp: got %b want 1", ifetch_resp); end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_ifetch();
    test_round_robin();
    test_write_capture();
    test_rw_both();
    test_reset_mid();
    test_spurious_resp();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
